// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op encodings as carried on the op port
//   - FSM state type
//   - wide two's-complement negate helper; callers size-cast the argument
//     up to MAX_W and the result back down to the width they need, so one
//     helper serves both the WIDTH-bit quotient/remainder and the
//     2*WIDTH-bit product (WIDTH up to 64).
package muldiv_pkg;

    localparam int MAX_W = 128;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shift datapath of the multiply/divide unit, one bit per step.
//   Multiply: shift-add; {upper, lower} ends as the 2*WIDTH-bit product of
//             the two magnitudes (lower starts as the multiplier).
//   Divide:   restoring; lower ends as the quotient, upper as the remainder.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            capture magnitudes and mode (is_div) for a new operation
//   step            perform one iteration
//   a_mag, b_mag    operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   hi_part         product upper half / remainder
//   lo_part         product lower half / quotient
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi_part,
    output logic [WIDTH-1:0] lo_part
);

    logic [WIDTH-1:0] upper_r;
    logic [WIDTH-1:0] lower_r;
    logic [WIDTH-1:0] operand_r;
    logic             div_mode_r;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;

    // Next-step arithmetic for both modes; the partial remainder is WIDTH+1 bits wide.
    always_comb begin
        sum_s     = {1'b0, upper_r} + (lower_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}});
        shifted_s = {upper_r, lower_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, operand_r};
    end

    // Accumulator / remainder registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            upper_r    <= '0;
            lower_r    <= '0;
            operand_r  <= '0;
            div_mode_r <= 1'b0;
        end else if (load) begin
            div_mode_r <= is_div;
            upper_r    <= '0;
            if (is_div) begin
                lower_r   <= a_mag;
                operand_r <= b_mag;
            end else begin
                lower_r   <= b_mag;
                operand_r <= a_mag;
            end
        end else if (step) begin
            if (div_mode_r) begin
                // A clear sign bit on the trial means the divisor fits: keep it, quotient bit 1.
                if (!trial_s[WIDTH]) begin
                    upper_r <= trial_s[WIDTH-1:0];
                    lower_r <= {lower_r[WIDTH-2:0], 1'b1};
                end else begin
                    upper_r <= shifted_s[WIDTH-1:0];
                    lower_r <= {lower_r[WIDTH-2:0], 1'b0};
                end
            end else begin
                upper_r <= sum_s[WIDTH:1];
                lower_r <= {sum_s[0], lower_r[WIDTH-1:1]};
            end
        end
    end

    assign hi_part = upper_r;
    assign lo_part = lower_r;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
//   A start pulse in IDLE latches the operation; WIDTH iterations run in RUN,
//   FIX applies sign correction and writes HI/LO, pulsing done. Latency is
//   WIDTH+1 edges for every op. flush aborts without touching HI/LO.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, op           request and operation (sampled in IDLE only)
//   srca, srcb          rs / rt operands
//   flush               abort the in-flight operation
//   hi_we, lo_we, wdata MTHI / MTLO writes (honoured in IDLE only)
//   busy, done, divzero status (all registered)
//   hi, lo              architectural HI / LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       op_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] a_raw_r;

    logic             is_signed_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             load_s;
    logic             step_s;
    logic [WIDTH-1:0] iter_hi_s;
    logic [WIDTH-1:0] iter_lo_s;
    logic [PW-1:0]    prod_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    // Operand magnitudes: signed ops take |x|, unsigned ops pass the raw bits.
    always_comb begin
        is_signed_s = (op == OP_MULT) || (op == OP_DIV);
        if (is_signed_s && srca[WIDTH-1]) begin
            a_mag_s = WIDTH'(twos_neg(MAX_W'(srca)));
        end else begin
            a_mag_s = srca;
        end
        if (is_signed_s && srcb[WIDTH-1]) begin
            b_mag_s = WIDTH'(twos_neg(MAX_W'(srcb)));
        end else begin
            b_mag_s = srcb;
        end
    end

    assign load_s = (state_r == IDLE) && start;
    assign step_s = (state_r == RUN);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .step    (step_s),
        .is_div  (op[1]),
        .a_mag   (a_mag_s),
        .b_mag   (b_mag_s),
        .hi_part (iter_hi_s),
        .lo_part (iter_lo_s)
    );

    // Sign correction of the magnitude result, plus the divide-by-zero override.
    always_comb begin
        prod_s   = PW'(twos_neg(MAX_W'({iter_hi_s, iter_lo_s})));
        fix_hi_s = iter_hi_s;
        fix_lo_s = iter_lo_s;
        case (op_r)
            OP_MULT: begin
                if (sign_a_r ^ sign_b_r) begin
                    fix_hi_s = prod_s[PW-1:WIDTH];
                    fix_lo_s = prod_s[WIDTH-1:0];
                end else begin
                    fix_hi_s = iter_hi_s;
                    fix_lo_s = iter_lo_s;
                end
            end
            OP_MULTU: begin
                fix_hi_s = iter_hi_s;
                fix_lo_s = iter_lo_s;
            end
            OP_DIV: begin
                // Most-negative / -1 falls out as the wrapped quotient with no special case.
                if (div_zero_r) begin
                    fix_hi_s = a_raw_r;
                    fix_lo_s = '1;
                end else begin
                    fix_hi_s = sign_a_r ? WIDTH'(twos_neg(MAX_W'(iter_hi_s))) : iter_hi_s;
                    fix_lo_s = (sign_a_r ^ sign_b_r) ? WIDTH'(twos_neg(MAX_W'(iter_lo_s))) : iter_lo_s;
                end
            end
            OP_DIVU: begin
                if (div_zero_r) begin
                    fix_hi_s = a_raw_r;
                    fix_lo_s = '1;
                end else begin
                    fix_hi_s = iter_hi_s;
                    fix_lo_s = iter_lo_s;
                end
            end
            default: begin
                fix_hi_s = iter_hi_s;
                fix_lo_s = iter_lo_s;
            end
        endcase
    end

    // Control FSM, iteration counter and the registered HI/LO/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= '0;
            op_r       <= OP_MULT;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            div_zero_r <= 1'b0;
            a_raw_r    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            divzero    <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    // start outranks flush here: flush only squashes older work.
                    if (start) begin
                        op_r       <= op;
                        sign_a_r   <= is_signed_s && srca[WIDTH-1];
                        sign_b_r   <= is_signed_s && srcb[WIDTH-1];
                        div_zero_r <= (srcb == '0);
                        a_raw_r    <= srca;
                        count_r    <= CNT_W'(WIDTH - 1);
                        busy       <= 1'b1;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else if (count_r == '0) begin
                        state_r <= FIX;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                FIX: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                    if (!flush) begin
                        hi      <= fix_hi_s;
                        lo      <= fix_lo_s;
                        done    <= 1'b1;
                        divzero <= op_r[1] && div_zero_r;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Expected results come from a plain 64-bit integer arithmetic model.
module tb_muldiv_unit;

    localparam logic [1:0] T_MULT  = 2'd0;
    localparam logic [1:0] T_MULTU = 2'd1;
    localparam logic [1:0] T_DIV   = 2'd2;
    localparam logic [1:0] T_DIVU  = 2'd3;

    logic        clk = 1'b0;
    logic        reset, start32, start8, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] srca, srcb, wdata;
    logic        busy, done, divzero, busy8, done8, divzero8;
    logic [31:0] hi, lo;
    logic [7:0]  hi8, lo8;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] last_hi, last_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op), .srca(srca[7:0]), .srcb(srcb[7:0]),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata[7:0]),
        .busy(busy8), .done(done8), .divzero(divzero8), .hi(hi8), .lo(lo8)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sign-extend to 64 bits, use native * / %, then split into HI/LO.
    function automatic void ref_model(input int w, input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] rhi,
                                      output logic [31:0] rlo, output logic rdz);
        longint unsigned mask, ua, ub, up;
        longint          sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        rdz  = 1'b0;
        up   = 64'd0;
        if (o == T_MULT) begin
            up = $unsigned(sa * sb);
        end else if (o == T_MULTU) begin
            up = ua * ub;
        end else if (ub == 64'd0) begin
            rdz = 1'b1;
            up  = (ua << w) | mask;
        end else if (o == T_DIV) begin
            q  = sa / sb;
            r  = sa % sb;
            up = (($unsigned(r) & mask) << w) | ($unsigned(q) & mask);
        end else begin
            up = ((ua % ub) << w) | (ua / ub);
        end
        rlo = 32'(up & mask);
        rhi = 32'((up >> w) & mask);
    endfunction

    function automatic logic o_done(input int w);
        return (w == 8) ? done8 : done;
    endfunction
    function automatic logic o_busy(input int w);
        return (w == 8) ? busy8 : busy;
    endfunction
    function automatic logic o_dz(input int w);
        return (w == 8) ? divzero8 : divzero;
    endfunction
    function automatic logic [31:0] o_hi(input int w);
        return (w == 8) ? {24'd0, hi8} : hi;
    endfunction
    function automatic logic [31:0] o_lo(input int w);
        return (w == 8) ? {24'd0, lo8} : lo;
    endfunction

    // Call at a negedge; issues one op (optionally with flush alongside start)
    // and returns at the negedge of the done cycle.
    task automatic do_op(input int w, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic fl);
        logic [31:0] ehi, elo;
        logic        edz;
        int          n, bc;
        ref_model(w, o, a, b, ehi, elo, edz);
        op = o; srca = a; srcb = b; flush = fl;
        if (w == 8) start8 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0; flush = 1'b0;
        check_eq($sformatf("w%0d_op%0d_done_low", w, o), 64'(o_done(w)), 64'd0);
        n = 0; bc = 0;
        while (o_done(w) == 1'b0 && n < 40) begin
            if (o_busy(w)) bc++;
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("w%0d_op%0d_latency", w, o), 64'(n), 64'(w + 1));
        check_eq($sformatf("w%0d_op%0d_busy_cycles", w, o), 64'(bc), 64'(w + 1));
        check_eq($sformatf("w%0d_op%0d_a%0h_b%0h_hi", w, o, a, b), 64'(o_hi(w)), 64'(ehi));
        check_eq($sformatf("w%0d_op%0d_a%0h_b%0h_lo", w, o, a, b), 64'(o_lo(w)), 64'(elo));
        check_eq($sformatf("w%0d_op%0d_divzero", w, o), 64'(o_dz(w)), 64'(edz));
        check_eq($sformatf("w%0d_op%0d_busy_at_done", w, o), 64'(o_busy(w)), 64'd0);
        if (w == 32) begin
            last_hi = ehi;
            last_lo = elo;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0080;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, dseen;
        reset = 1'b1; start32 = 1'b0; start8 = 1'b0; flush = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; op = 2'd0; srca = 32'd0; srcb = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_divzero", 64'(divzero), 64'd0);
        check_eq("reset_hi", 64'(hi), 64'd0);
        check_eq("reset_lo", 64'(lo), 64'd0);
        check_eq("reset_hi8", 64'(hi8), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, back to back (each new start lands in the done cycle).
        do_op(32, T_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check_eq("mult_neg3x7_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mult_neg3x7_lo", 64'(lo), 64'hFFFF_FFEB);
        do_op(32, T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check_eq("multu_max_lo", 64'(lo), 64'h0000_0001);
        do_op(32, T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_neg7_2_lo", 64'(lo), 64'hFFFF_FFFD);
        check_eq("div_neg7_2_hi", 64'(hi), 64'hFFFF_FFFF);
        do_op(32, T_DIVU, 32'd100, 32'd7, 1'b0);
        check_eq("divu_100_7_lo", 64'(lo), 64'd14);
        check_eq("divu_100_7_hi", 64'(hi), 64'd2);
        do_op(32, T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_minneg_lo", 64'(lo), 64'h8000_0000);
        check_eq("div_minneg_hi", 64'(hi), 64'd0);
        do_op(32, T_DIVU, 32'd5, 32'd0, 1'b0);
        check_eq("divu_by0_lo", 64'(lo), 64'hFFFF_FFFF);
        check_eq("divu_by0_hi", 64'(hi), 64'd5);
        check_eq("divu_by0_flag", 64'(divzero), 64'd1);
        do_op(32, T_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
        // Start together with flush in IDLE: start must win.
        do_op(32, T_MULT, 32'd12345, 32'hFFFF_FF85, 1'b1);

        do_op(8, T_MULT, 32'h0000_00FD, 32'd7, 1'b0);
        check_eq("w8_mult_hi", 64'(hi8), 64'hFF);
        check_eq("w8_mult_lo", 64'(lo8), 64'hEB);

        for (int i = 0; i < 30; i++) do_op(32, 2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
        for (int i = 0; i < 20; i++) do_op(8, 2'($urandom_range(0, 3)), pick(), pick(), 1'b0);

        // start while busy is ignored: result and latency stay those of the first op.
        do_op(32, T_DIVU, 32'd100, 32'd7, 1'b0);
        op = T_MULT; srca = 32'd6; srcb = 32'd9; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (3) @(negedge clk);
        op = T_DIVU; srca = 32'd1000; srcb = 32'd3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n = 4;
        while (done == 1'b0 && n < 40) begin @(negedge clk); n++; end
        check_eq("busy_start_latency", 64'(n), 64'd33);
        check_eq("busy_start_lo", 64'(lo), 64'd54);
        check_eq("busy_start_hi", 64'(hi), 64'd0);
        dseen = 0;
        repeat (40) begin @(negedge clk); if (done) dseen++; end
        check_eq("busy_start_no_second_done", 64'(dseen), 64'd0);

        // Flush during RUN: no done, HI/LO keep prior values; MTHI while busy ignored.
        do_op(32, T_DIVU, 32'd100, 32'd7, 1'b0);
        op = T_MULT; srca = 32'hFFFF_FFFD; srcb = 32'd7; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (8) @(negedge clk);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy_drop", 64'(busy), 64'd0);
        dseen = 0;
        repeat (40) begin if (done) dseen++; @(negedge clk); end
        check_eq("flush_no_done", 64'(dseen), 64'd0);
        check_eq("flush_hi_kept", 64'(hi), 64'(last_hi));
        check_eq("flush_lo_kept", 64'(lo), 64'(last_lo));

        // MTHI / MTLO in IDLE.
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check_eq("mthi_hi", 64'(hi), 64'h1234);
        check_eq("mthi_lo_kept", 64'(lo), 64'(last_lo));
        lo_we = 1'b1; wdata = 32'hCAFE_0042;
        @(negedge clk);
        lo_we = 1'b0;
        check_eq("mtlo_lo", 64'(lo), 64'hCAFE_0042);

        // Reset in the middle of RUN.
        op = T_MULTU; srca = 32'hFFFF_FFFF; srcb = 32'd3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midreset_busy", 64'(busy), 64'd0);
        check_eq("midreset_done", 64'(done), 64'd0);
        check_eq("midreset_divzero", 64'(divzero), 64'd0);
        check_eq("midreset_hi", 64'(hi), 64'd0);
        check_eq("midreset_lo", 64'(lo), 64'd0);
        dseen = 0;
        repeat (40) begin @(negedge clk); if (done) dseen++; end
        check_eq("midreset_no_done", 64'(dseen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the execute-stage ALU: the execute stage issues MULT/MULTU/DIV/DIVU via a one-cycle start pulse, and the unit iterates one bit per cycle. While it iterates, `busy` feeds the hazard unit so that MFHI/MFLO/MTHI/MTLO and new mul/div ops stall in decode. Replaces single-cycle ALU-only arithmetic with a width-generic, abortable engine.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4 and even.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- srca  in  WIDTH  multiplicand / dividend (rs).
- srcb  in  WIDTH  multiplier / divisor (rt).
- flush  in  1  abort in-flight operation (branch/exception squash).
- hi_we, lo_we  in  1 each  MTHI/MTLO write enables.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight; reset 0.
- done  out  1  one-cycle pulse, HI/LO hold new result; reset 0.
- divzero  out  1  pulses with done when a divide had srcb=0; reset 0.
- hi, lo  out  WIDTH each  architectural HI/LO; reset 0.

## Operation
- States: IDLE, RUN, FIX. Reset → IDLE, counter 0, hi=lo=0, busy=done=divzero=0.
- IDLE: start=1 latches op, magnitudes of srca/srcb (signed ops take |x|; unsigned use raw), sign flags, zero-divisor flag; → RUN, counter=WIDTH-1.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 2·WIDTH accumulator.
- RUN, divide: restoring, one quotient bit per cycle; remainder WIDTH+1 bits internally.
- RUN: counter decrements each cycle; at counter 0 → FIX.
- FIX: sign correction, then write HI/LO; → IDLE.
  - MULT: product negated (two's complement, 2·WIDTH) iff operand signs differ; HI=upper, LO=lower.
  - DIV: quotient negated iff signs differ; remainder takes dividend sign; HI=remainder, LO=quotient.
  - Unsigned ops: no correction.
  - Divisor 0, any divide: LO=all ones, HI=srca as latched (original, not magnitude), divzero=1.
  - Signed DIV of most-negative by −1: LO=most-negative, HI=0 (natural wrap, no flag).
- start while busy: ignored; no queueing.
- flush in RUN or FIX: → IDLE next edge; HI/LO unchanged; no done.
- flush and start together in IDLE: start wins (flush covers older instructions only).
- hi_we/lo_we in IDLE: hi/lo ← wdata next edge. While busy: ignored; hazard unit prevents this.
- hi_we and done-producing FIX edge cannot coincide (busy=1 in FIX).
- reset mid-operation: same-edge return to reset state, HI/LO cleared.

## Timing
- Start sampled at edge 0 → busy=1 from edge 0 through edge WIDTH+1; RUN occupies edges 1..WIDTH; FIX at edge WIDTH+1.
- After edge WIDTH+1: busy=0, done=1, hi/lo new, divzero valid, for exactly one cycle (done/divzero then return to 0).
- Latency start→result visible: WIDTH+1 edges, identical for all ops and divide-by-zero.
- Back-to-back: new start accepted in the done cycle.
- hi/lo are registered outputs; no combinational path from inputs to any output.

## Structure
- Package muldiv_pkg: op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE/RUN/FIX), helper function for WIDTH-bit two's-complement negate.
- Single module; optional sub-module muldiv_iter holding accumulator/remainder shift logic, with the FSM, counter, sign fix and HI/LO in muldiv_unit.
- Counter width $clog2(WIDTH).

## Test plan
- MULT srca=−3 (0xFFFFFFFD), srcb=7 → after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulse 1 cycle, busy 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); DIVU 100/7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, divzero=0; DIVU 5/0 → LO=0xFFFFFFFF, HI=5, divzero=1.
- Start MULT, flush at RUN cycle 10 → busy drops next edge, no done, HI/LO keep prior values; start during busy ignored; MTHI 0x1234 in IDLE → hi=0x1234 next edge.
- reset at RUN cycle 5 → all outputs 0 next edge; repeat the first scenario with WIDTH=8 (−3×7 → HI=0xFF, LO=0xEB after 9 edges).
